// File: rtl/serv_mtimer_if.sv
// Wishbone classic slave port of the machine timer: 2-bit word address,
// 32-bit data, byte-lane selects and a single-cycle acknowledge.
interface serv_mtimer_if;
  logic [1:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/serv_mtimer.sv
// RISC-V machine timer: prescaled free-running mtime and an mtimecmp compare
// register on a 32-bit Wishbone slave port. o_irq is a registered level
// (mtime >= mtimecmp) feeding the CSR unit's mtip input, which does its own
// edge detection and enable gating.
module serv_mtimer #(
  parameter int WIDTH = 64,  // 32 or 64
  parameter int DIV   = 1    // mtime advances once every DIV cycles
) (
  input  logic        i_clk,
  input  logic        i_rst,
  serv_mtimer_if.slave wb,
  output logic        o_irq
);

  localparam int              PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);
  localparam logic            HI   = (WIDTH == 64);

  // Replace only the byte lanes enabled in sel.
  function automatic logic [31:0] f_merge(input logic [31:0] old,
                                          input logic [31:0] dat,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
    end
    return res;
  endfunction

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [WIDTH-1:0] r_mtime;
  logic [WIDTH-1:0] r_mtimecmp;
  logic [WIDTH-1:0] w_mtime_nxt;
  logic [WIDTH-1:0] w_cmp_nxt;
  logic [31:0]      w_mlo_mrg;
  logic [31:0]      w_clo_mrg;
  logic [31:0]      w_rd_mhi;
  logic [31:0]      w_rd_chi;
  logic [31:0]      r_rdt;
  logic             r_ack;
  logic             r_irq;
  logic             w_req;
  logic             w_wr;
  logic             w_rd;
  logic             w_mtime_we;
  logic             w_cmp_we;

  // Handshake: a request is cyc & stb while ack is low; it is accepted in
  // that cycle with no wait states and answered by ack (with read data) in
  // the next cycle for exactly one cycle. Masking with ack means a master
  // holding stb gets one ack every two cycles.
  assign w_req = wb.i_wb_cyc & wb.i_wb_stb & ~r_ack;
  assign w_wr  = w_req & wb.i_wb_we;
  assign w_rd  = w_req & ~wb.i_wb_we;

  // Upper-word addresses only decode to a register when WIDTH is 64;
  // otherwise the write is acknowledged and dropped.
  assign w_mtime_we = w_wr & ((wb.i_wb_adr == 2'd0) | (HI & (wb.i_wb_adr == 2'd1)));
  assign w_cmp_we   = w_wr & ((wb.i_wb_adr == 2'd2) | (HI & (wb.i_wb_adr == 2'd3)));

  assign w_tick    = (r_presc == LAST);
  assign w_mlo_mrg = f_merge(r_mtime[31:0], wb.i_wb_dat, wb.i_wb_sel);
  assign w_clo_mrg = f_merge(r_mtimecmp[31:0], wb.i_wb_dat, wb.i_wb_sel);

  generate
    if (WIDTH == 64) begin : g_w64
      logic [31:0] r_hi_shadow;

      // Reading mtime_lo snapshots the upper word so a following mtime_hi
      // read is coherent with it even if a carry happened in between.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_hi_shadow <= 32'd0;
        end else if (w_rd && (wb.i_wb_adr == 2'd0)) begin
          r_hi_shadow <= r_mtime[WIDTH-1:32];
        end
      end

      // Address bit 0 picks which half a write lands in; the other half
      // keeps its current value.
      assign w_mtime_nxt = wb.i_wb_adr[0]
        ? {f_merge(r_mtime[WIDTH-1:32], wb.i_wb_dat, wb.i_wb_sel), r_mtime[31:0]}
        : {r_mtime[WIDTH-1:32], w_mlo_mrg};
      assign w_cmp_nxt = wb.i_wb_adr[0]
        ? {f_merge(r_mtimecmp[WIDTH-1:32], wb.i_wb_dat, wb.i_wb_sel), r_mtimecmp[31:0]}
        : {r_mtimecmp[WIDTH-1:32], w_clo_mrg};
      assign w_rd_mhi = r_hi_shadow;
      assign w_rd_chi = r_mtimecmp[WIDTH-1:32];
    end else begin : g_w32
      assign w_mtime_nxt = w_mlo_mrg;
      assign w_cmp_nxt   = w_clo_mrg;
      assign w_rd_mhi    = 32'd0;
      assign w_rd_chi    = 32'd0;
    end
  endgenerate

  // Prescaler runs 0..DIV-1 undisturbed by bus writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // mtime: a bus write beats a coincident tick (that increment is lost);
  // wraps silently at all ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtime <= '0;
    end else if (w_mtime_we) begin
      r_mtime <= w_mtime_nxt;
    end else if (w_tick) begin
      r_mtime <= r_mtime + WIDTH'(1);
    end
  end

  // mtimecmp resets to all ones so nothing fires before software sets it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtimecmp <= '1;
    end else if (w_cmp_we) begin
      r_mtimecmp <= w_cmp_nxt;
    end
  end

  // Acknowledge one cycle after each accepted request; reset drops any
  // request in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_req;
    end
  end

  // Read data is registered alongside ack and held between reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdt <= 32'd0;
    end else if (w_rd) begin
      case (wb.i_wb_adr)
        2'd0:    r_rdt <= r_mtime[31:0];
        2'd1:    r_rdt <= w_rd_mhi;
        2'd2:    r_rdt <= r_mtimecmp[31:0];
        default: r_rdt <= w_rd_chi;
      endcase
    end
  end

  // Interrupt level from the current register values; a compare change in
  // cycle N shows on o_irq in cycle N+1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign wb.o_wb_ack = r_ack;
  assign wb.o_wb_rdt = r_rdt;
  assign o_irq       = r_irq;

endmodule

// File: tb/tb_serv_mtimer.sv
// Bench for serv_mtimer: three instances (64-bit DIV=1, 64-bit DIV=4,
// 32-bit DIV=1) driven by directed bus transfers. Each transfer pushes its
// expected read data; per-instance monitors pop and compare on every ack.
module tb_serv_mtimer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  serv_mtimer_if wb1();
  serv_mtimer_if wb4();
  serv_mtimer_if wb32();
  logic irq1, irq4, irq32;

  serv_mtimer #(.WIDTH(64), .DIV(1)) u_d1  (.i_clk(clk), .i_rst(rst), .wb(wb1),  .o_irq(irq1));
  serv_mtimer #(.WIDTH(64), .DIV(4)) u_d4  (.i_clk(clk), .i_rst(rst), .wb(wb4),  .o_irq(irq4));
  serv_mtimer #(.WIDTH(32), .DIV(1)) u_d32 (.i_clk(clk), .i_rst(rst), .wb(wb32), .o_irq(irq32));

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q1[$],  exp_q4[$],  exp_q32[$];
  bit          chk_q1[$],  chk_q4[$],  chk_q32[$];
  string       nm_q1[$],   nm_q4[$],   nm_q32[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: ack seen, none expected", nm);
  endtask

  always @(negedge clk) begin
    logic [31:0] e; bit c; string s;
    if (wb1.o_wb_ack === 1'b1) begin
      if (exp_q1.size() == 0) fail_now("d1_spurious_ack");
      else begin
        e = exp_q1.pop_front(); c = chk_q1.pop_front(); s = nm_q1.pop_front();
        if (c) check(s, wb1.o_wb_rdt, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e; bit c; string s;
    if (wb4.o_wb_ack === 1'b1) begin
      if (exp_q4.size() == 0) fail_now("d4_spurious_ack");
      else begin
        e = exp_q4.pop_front(); c = chk_q4.pop_front(); s = nm_q4.pop_front();
        if (c) check(s, wb4.o_wb_rdt, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e; bit c; string s;
    if (wb32.o_wb_ack === 1'b1) begin
      if (exp_q32.size() == 0) fail_now("d32_spurious_ack");
      else begin
        e = exp_q32.pop_front(); c = chk_q32.pop_front(); s = nm_q32.pop_front();
        if (c) check(s, wb32.o_wb_rdt, e);
      end
    end
  end

  // irq edge recorders (cycle stamp at the negedge the new level is seen)
  int   rise1 = -1, fall1 = -1, rise32 = -1, fall32 = -1;
  logic p1 = 1'b0, p32 = 1'b0;

  always @(negedge clk) begin
    if (irq1 === 1'b1 && p1 === 1'b0) rise1 = cnt;
    if (irq1 === 1'b0 && p1 === 1'b1) fall1 = cnt;
    p1 = irq1;
    if (irq32 === 1'b1 && p32 === 1'b0) rise32 = cnt;
    if (irq32 === 1'b0 && p32 === 1'b1) fall32 = cnt;
    p32 = irq32;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic cyc, input logic we, input logic [1:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    case (d)
      1: begin
        wb1.i_wb_cyc = cyc; wb1.i_wb_stb = cyc; wb1.i_wb_we = we;
        wb1.i_wb_adr = adr; wb1.i_wb_dat = dat; wb1.i_wb_sel = sel;
      end
      4: begin
        wb4.i_wb_cyc = cyc; wb4.i_wb_stb = cyc; wb4.i_wb_we = we;
        wb4.i_wb_adr = adr; wb4.i_wb_dat = dat; wb4.i_wb_sel = sel;
      end
      default: begin
        wb32.i_wb_cyc = cyc; wb32.i_wb_stb = cyc; wb32.i_wb_we = we;
        wb32.i_wb_adr = adr; wb32.i_wb_dat = dat; wb32.i_wb_sel = sel;
      end
    endcase
  endtask

  function automatic logic get_ack(input int d);
    case (d)
      1:       return wb1.o_wb_ack;
      4:       return wb4.o_wb_ack;
      default: return wb32.o_wb_ack;
    endcase
  endfunction

  task automatic push(input int d, input bit chk, input logic [31:0] exp, input string nm);
    case (d)
      1:       begin exp_q1.push_back(exp);  chk_q1.push_back(chk);  nm_q1.push_back(nm);  end
      4:       begin exp_q4.push_back(exp);  chk_q4.push_back(chk);  nm_q4.push_back(nm);  end
      default: begin exp_q32.push_back(exp); chk_q32.push_back(chk); nm_q32.push_back(nm); end
    endcase
  endtask

  // Called at a negedge: request in this cycle, ack expected next cycle,
  // returns two negedges later so transfers are spaced by two cycles.
  task automatic xfer(input int d, input logic we, input logic [1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit chk, input logic [31:0] exp, input string nm);
    push(d, chk, exp, nm);
    drive(d, 1'b1, we, adr, dat, sel);
    @(negedge clk);
    check({nm, "_ack"}, 32'(get_ack(d)), 32'd1);
    drive(d, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
    @(negedge clk);
  endtask

  task automatic rd(input int d, input logic [1:0] adr, input logic [31:0] exp, input string nm);
    xfer(d, 1'b0, adr, 32'd0, 4'd0, 1'b1, exp, nm);
  endtask

  task automatic rd_nc(input int d, input logic [1:0] adr, input string nm);
    xfer(d, 1'b0, adr, 32'd0, 4'd0, 1'b0, 32'd0, nm);
  endtask

  task automatic wr(input int d, input logic [1:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input string nm);
    xfer(d, 1'b1, adr, dat, sel, 1'b0, 32'd0, nm);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: still running at 200000, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int m, w, n_acks, b2b;
    logic pa;

    drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
    drive(4, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
    drive(32, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // reset state
    check("rst_ack_d1",  32'(wb1.o_wb_ack), 32'd0);
    check("rst_rdt_d1",  wb1.o_wb_rdt,      32'd0);
    check("rst_irq_d1",  32'(irq1),         32'd0);
    check("rst_ack_d4",  32'(wb4.o_wb_ack), 32'd0);
    check("rst_rdt_d4",  wb4.o_wb_rdt,      32'd0);
    check("rst_irq_d4",  32'(irq4),         32'd0);
    check("rst_ack_d32", 32'(wb32.o_wb_ack), 32'd0);
    check("rst_rdt_d32", wb32.o_wb_rdt,     32'd0);
    check("rst_irq_d32", 32'(irq32),        32'd0);

    // release; read mtime_lo at once and again after one idle cycle
    rst = 1'b0;
    rd(1, 2'd0, 32'd0, "t1_mtime_lo_first");
    @(negedge clk);
    rd(1, 2'd0, 32'd3, "t1_mtime_lo_second");
    rd(1, 2'd2, 32'hFFFF_FFFF, "t1_cmp_lo_reset");
    rd(1, 2'd3, 32'hFFFF_FFFF, "t1_cmp_hi_reset");
    check("t1_irq_low", 32'(irq1), 32'd0);

    // interrupt threshold crossing and release
    wr(1, 2'd3, 32'd0,     4'hF, "t4_cmp_hi_wr");
    wr(1, 2'd2, 32'h110,   4'hF, "t4_cmp_lo_wr");
    m = cnt;
    wr(1, 2'd0, 32'h100,   4'hF, "t4_mtime_lo_wr");
    for (int i = 0; i < 40; i++) begin
      if (rise1 >= 0) break;
      @(negedge clk);
    end
    check("t4_irq_rise_latency", 32'(rise1 - m), 32'd18);
    check("t4_irq_high", 32'(irq1), 32'd1);
    fall1 = -1;
    w = cnt;
    wr(1, 2'd2, 32'hFFFF_0000, 4'hF, "t4_cmp_raise_wr");
    @(negedge clk);
    check("t4_irq_fall_latency", 32'(fall1 - w), 32'd2);
    check("t4_irq_low", 32'(irq1), 32'd0);

    // carry coherence across lo/hi read pair
    wr(1, 2'd1, 32'd0, 4'hF, "t3_mtime_hi_wr");
    wr(1, 2'd0, 32'hFFFF_FFF0, 4'hF, "t3_mtime_lo_wr");
    repeat (20) @(negedge clk);
    rd(1, 2'd0, 32'h5, "t3_mtime_lo_after_carry");
    rd(1, 2'd1, 32'h1, "t3_mtime_hi_shadow");
    wr(1, 2'd1, 32'h9, 4'hF, "t3_mtime_hi_wr9");
    rd(1, 2'd1, 32'h1, "t3_hi_is_shadow_not_live");
    rd_nc(1, 2'd0, "t3_lo_recapture");
    rd(1, 2'd1, 32'h9, "t3_hi_after_recapture");

    // byte lanes on mtimecmp
    wr(1, 2'd2, 32'h1122_3344, 4'hF,    "t5_cmp_lo_full");
    wr(1, 2'd2, 32'hAABB_CCDD, 4'b0101, "t5_cmp_lo_lanes");
    rd(1, 2'd2, 32'h11BB_33DD, "t5_cmp_lo_merged");
    wr(1, 2'd2, 32'h0000_0000, 4'b0000, "t5_cmp_lo_sel0");
    rd(1, 2'd2, 32'h11BB_33DD, "t5_cmp_lo_sel0_unchanged");
    wr(1, 2'd3, 32'hCAFE_1234, 4'b1100, "t5_cmp_hi_lanes");
    rd(1, 2'd3, 32'hCAFE_0000, "t5_cmp_hi_merged");

    // DIV=4: 40 cycles after the write's ack gives exactly 10 ticks
    wr(4, 2'd0, 32'd0, 4'hF, "t2_mtime_lo_wr");
    repeat (39) @(negedge clk);
    rd(4, 2'd0, 32'd10, "t2_mtime_lo_div4");
    repeat (2) @(negedge clk);
    rd(4, 2'd0, 32'd11, "t2_mtime_lo_div4_next");
    rd(4, 2'd1, 32'd0,  "t2_mtime_hi_div4");
    check("t2_irq_low", 32'(irq4), 32'd0);

    // held strobe on the 32-bit instance: ack, idle, ack, idle, ...
    for (int i = 0; i < 3; i++) push(32, 1'b1, 32'hFFFF_FFFF, "t6_hold_cmp_lo");
    drive(32, 1'b1, 1'b0, 2'd2, 32'd0, 4'd0);
    n_acks = 0; b2b = 0; pa = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wb32.o_wb_ack === 1'b1) begin
        n_acks++;
        if (pa) b2b++;
      end
      pa = wb32.o_wb_ack;
    end
    drive(32, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
    check("t6_hold_ack_count", 32'(n_acks), 32'd3);
    check("t6_hold_back_to_back", 32'(b2b), 32'd0);
    @(negedge clk);

    // WIDTH=32 upper words
    wr(32, 2'd1, 32'h5, 4'hF, "t6_w32_mtime_hi_wr");
    rd(32, 2'd1, 32'd0, "t6_w32_mtime_hi_rd");
    rd(32, 2'd3, 32'd0, "t6_w32_cmp_hi_rd");

    // WIDTH=32 wrap; irq level follows mtime through all-ones and back to 0
    rise32 = -1; fall32 = -1;
    w = cnt;
    wr(32, 2'd0, 32'hFFFF_FFFE, 4'hF, "t7_w32_mtime_lo_wr");
    rd(32, 2'd0, 32'hFFFF_FFFF, "t7_w32_at_max");
    rd(32, 2'd0, 32'h0000_0001, "t7_w32_wrapped");
    @(negedge clk);
    check("t7_w32_irq_rise", 32'(rise32 - w), 32'd3);
    check("t7_w32_irq_fall", 32'(fall32 - w), 32'd4);

    // reset while a request is presented: no ack, state back to reset
    drive(1, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t8_rst_drop_ack", 32'(wb1.o_wb_ack), 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
    @(negedge clk);
    check("t8_rst_drop_ack_hold", 32'(wb1.o_wb_ack), 32'd0);
    rst = 1'b0;
    rd(1, 2'd0, 32'd0, "t8_mtime_lo_after_rst");
    rd(1, 2'd2, 32'hFFFF_FFFF, "t8_cmp_lo_after_rst");
    check("t8_irq_after_rst", 32'(irq1), 32'd0);

    repeat (2) @(negedge clk);
    check("end_q1_empty",  32'(exp_q1.size()),  32'd0);
    check("end_q4_empty",  32'(exp_q4.size()),  32'd0);
    check("end_q32_empty", 32'(exp_q32.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serv_mtimer.md
Name: serv_mtimer

Overview:
- RISC-V machine timer peripheral: free-running mtime counter plus mtimecmp compare register, both on a 32-bit Wishbone slave port.
- Sits directly upstream of the CSR unit. o_irq drives the CSR unit's i_mtip input.
- The CSR unit does its own edge detection and mstatus.MIE/mie.MTIE gating, so o_irq is a plain level signal.

Parameters:
- WIDTH, 64, counter and compare width; legal values are 32 or 64.
- DIV, 1, mtime increments once every DIV clock cycles; DIV >= 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_wb_adr  in  2  word select: 0=mtime_lo, 1=mtime_hi, 2=mtimecmp_lo, 3=mtimecmp_hi
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte-lane write enables
- i_wb_we  in  1  write strobe qualifier
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe
- o_wb_rdt  out  32  read data, valid with ack
- o_wb_ack  out  1  single-cycle acknowledge
- o_irq  out  1  timer interrupt pending (mtime >= mtimecmp)

Behaviour:
- Reset values:
  - mtime = 0, prescaler = 0, hi_shadow = 0
  - mtimecmp = all ones (no spurious irq)
  - o_irq = 0, o_wb_ack = 0, o_wb_rdt = 0
- Reset mid-operation: a transaction in flight when reset asserts is dropped; no ack is issued.
- Prescaler:
  - Counts 0..DIV-1. tick = (prescaler == DIV-1).
  - On tick, prescaler returns to 0 and mtime increments by 1.
  - DIV=1 means tick every cycle.
- mtime wraps from all ones to 0 with no flag.
- Bus handshake:
  - Request: req = cyc & stb & !o_wb_ack.
  - o_wb_ack is asserted the cycle after req and lasts exactly one cycle.
  - A held stb produces one ack per two cycles (ack, then idle).
  - No wait states. All four addresses ack, including unused ones.
- Writes (req & we):
  - Update the selected register per byte lane in i_wb_sel; sel=0 is a legal no-op that still acks.
  - A write to mtime in the same cycle as a tick wins; that increment is lost.
  - The prescaler is not disturbed by writes.
  - 64-bit updates are non-atomic; software sequences the two halves.
- Reads (req & !we):
  - o_wb_rdt is registered and presented together with ack.
  - Reading mtime_lo returns the current low word and, in the same cycle, captures mtime[63:32] into hi_shadow.
  - Reading mtime_hi returns hi_shadow, not the live value. A lo-then-hi read pair is therefore coherent across a carry.
  - mtimecmp reads return the live value.
  - o_wb_rdt keeps its last value when ack is low.
- WIDTH=32:
  - mtime_hi and mtimecmp_hi read 0; writes to them are acked and ignored.
  - hi_shadow is not implemented.
- o_irq:
  - Registered: o_irq <= (mtime >= mtimecmp), unsigned, full WIDTH. Evaluated every cycle on the current register values.
  - Latency: one cycle after the mtime/mtimecmp change that crosses the threshold.
  - Level-sensitive. Stays high until mtimecmp is raised above mtime, or mtime wraps below mtimecmp.
  - A write to mtimecmp in cycle N takes effect on o_irq in cycle N+2 (register update, then compare register).
- Simultaneous tick and mtimecmp write: the compare uses the post-update values of both registers.
- Expected implementation size: about 150-250 lines.

Test Plan:
- Reset, DIV=1, WIDTH=64: after i_rst release, read mtime_lo twice with 1 idle cycle between → values differ by 3. mtimecmp_lo and mtimecmp_hi read 0xFFFFFFFF. o_irq = 0.
- DIV=4: write mtime_lo=0, then read mtime_lo exactly 40 cycles after the write's ack → 10 (±1 for prescaler phase). mtime_hi read returns 0.
- Carry coherence: write mtime_hi=0, mtime_lo=0xFFFFFFF0, idle 20 cycles. Read lo → small value (0x4 region); then read hi → 1, with hi_shadow captured at the lo read.
- Interrupt: mtime=0x100, mtimecmp_hi=0, mtimecmp_lo=0x110, DIV=1 → o_irq rises when mtime reaches 0x110, plus 1 cycle. Write mtimecmp_lo=0xFFFF0000 → o_irq falls 2 cycles after the write request.
- Byte lanes: write mtimecmp_lo=0xAABBCCDD with sel=4'b0101 over an old value of 0x11223344 → reads 0x11BB33DD. A sel=0 write acks and leaves the register unchanged.
- Handshake/WIDTH=32: hold cyc&stb high for 6 cycles → exactly 3 ack pulses, never back-to-back. With WIDTH=32, write mtime_hi=0x5 → acked; read returns 0.
